// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
// Registered result stage that sits directly after the 32-bit ALU. It
// captures the ALU result, its flags and the issuing control code into a
// small FIFO under a valid/ready handshake. This decouples the combinational
// ALU from the writeback consumer. Flags that mean nothing for the op are
// masked to 0 before they are stored.
//
// The block also keeps two status registers:
//   - a sticky overflow bit, set by any accepted entry whose stored overflow
//     is 1;
//   - a modulo counter of accepted entries.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready depends only on the
//                       registered occupancy
//   alu_result, alu_zero, alu_cout, alu_overflow, alu_control
//                       ALU outputs and the op code that produced them
//   out_valid/out_ready downstream handshake for the head entry
//   out_result, out_zero, out_cout, out_overflow, out_op
//                       fields of the head entry, all registered
//   clr_sticky          clears sticky_ovf; a set in the same cycle wins
//   sticky_ovf          sticky masked-overflow status
//   op_count            accepted entries, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_overflow,
  output logic [3:0]       out_op,
  input  logic             clr_sticky,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] op_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic [3:0]  op;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_entry;
  entry_t          head_q;
  entry_t          head_next;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_next;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Overflow is only meaningful for add/sub.
  // Carry is also meaningful for slt, which is computed with a subtract.
  always_comb begin
    in_entry.result = alu_result;
    in_entry.zero   = alu_zero;
    in_entry.op     = alu_control;
    in_entry.ovf    = alu_overflow &
                      ((alu_control == OP_ADD) || (alu_control == OP_SUB));
    in_entry.cout   = alu_cout &
                      ((alu_control == OP_ADD) || (alu_control == OP_SUB) ||
                       (alu_control == OP_SLT));
  end

  // The head register always presents the entry that will be at the front
  // after this edge. The incoming entry becomes the head only when it will
  // be the sole occupant. Otherwise the head is read from storage; that slot
  // is never the one being written this cycle. When the FIFO drains, the
  // head register simply holds the last popped entry.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    rd_next   = pop ? rd_ptr + PW'(1) : rd_ptr;
    head_next = head_q;
    if (count_next != '0) begin
      if (push && (count_next == CW'(1))) begin
        head_next = in_entry;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  // Storage carries no reset. Reads only ever target slots below the
  // registered occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_q     <= '0;
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr     <= rd_next;
      count      <= count_next;
      head_q     <= head_next;
      sticky_ovf <= (sticky_ovf & ~clr_sticky) | (push & in_entry.ovf);
      op_count   <= op_count + CNT_W'(push);
    end
  end

  assign out_result   = head_q.result;
  assign out_zero     = head_q.zero;
  assign out_cout     = head_q.cout;
  assign out_overflow = head_q.ovf;
  assign out_op       = head_q.op;

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
// Scoreboard bench for alu_result_stage (DEPTH=2, CNT_W=4).
//
// Timing within each 10-unit clock period:
//   - the driver changes inputs 1 unit after posedge;
//   - the output monitor samples at negedge;
//   - the input monitor samples 1 unit before the next posedge.
//
// The expected FIFO contents are a queue of masked entries. Acceptance is
// decided from the queue occupancy, never from the DUT.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic [3:0]  op;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             alu_cout;
  logic             alu_overflow;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_zero;
  logic             out_cout;
  logic             out_overflow;
  logic [3:0]       out_op;
  logic             clr_sticky;
  logic             sticky_ovf;
  logic [CNT_W-1:0] op_count;

  int   checks;
  int   fails;
  exp_t sb_q[$];
  exp_t last_popped;
  bit   pop_pending;
  bit   model_sticky;
  int   model_count;

  alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .alu_control  (alu_control),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_cout     (out_cout),
    .out_overflow (out_overflow),
    .out_op       (out_op),
    .clr_sticky   (clr_sticky),
    .sticky_ovf   (sticky_ovf),
    .op_count     (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference rule: overflow survives only for add (2) and sub (6);
  // carry survives for add, sub and slt (7).
  function automatic exp_t modelEntry(input logic [31:0] r, input logic z,
                                      input logic c, input logic o,
                                      input logic [3:0] op);
    exp_t e;
    int   code;
    code     = int'(op);
    e.result = r;
    e.zero   = z;
    e.op     = op;
    e.ovf    = o && (code == 2 || code == 6);
    e.cout   = c && (code == 2 || code == 6 || code == 7);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] r,
                               input logic z, input logic c, input logic o,
                               input logic [3:0] op, input bit ordy,
                               input bit clr, input bit rs);
    @(posedge clk);
    #1;
    in_valid     = v;
    alu_result   = r;
    alu_zero     = z;
    alu_cout     = c;
    alu_overflow = o;
    alu_control  = op;
    out_ready    = ordy;
    clr_sticky   = clr;
    rst          = rs;
  endtask

  // Output monitor: checks the head against the scoreboard, or against the
  // held last-popped entry when empty, and pops on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        checkOutput("sticky_ovf", 64'(sticky_ovf), 64'(model_sticky));
        checkOutput("op_count", 64'(op_count), 64'(model_count));
        if (sb_q.size() != 0) begin
          checkOutput("out_result", 64'(out_result), 64'(sb_q[0].result));
          checkOutput("out_zero", 64'(out_zero), 64'(sb_q[0].zero));
          checkOutput("out_cout", 64'(out_cout), 64'(sb_q[0].cout));
          checkOutput("out_overflow", 64'(out_overflow), 64'(sb_q[0].ovf));
          checkOutput("out_op", 64'(out_op), 64'(sb_q[0].op));
          if (out_ready) begin
            last_popped = sb_q.pop_front();
            pop_pending = 1'b1;
          end
        end else begin
          checkOutput("hold_result", 64'(out_result), 64'(last_popped.result));
          checkOutput("hold_op", 64'(out_op), 64'(last_popped.op));
        end
      end
    end
  end

  // Input monitor: decides acceptance from model occupancy (before this
  // edge's pop), then updates the sticky and counter model.
  initial begin
    exp_t e;
    int   occ;
    bit   exp_ready;
    bit   acc;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        sb_q.delete();
        last_popped  = '{32'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        model_sticky = 1'b0;
        model_count  = 0;
      end else begin
        occ       = sb_q.size() + (pop_pending ? 1 : 0);
        exp_ready = (occ < DEPTH);
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        acc = in_valid && exp_ready;
        e   = modelEntry(alu_result, alu_zero, alu_cout, alu_overflow, alu_control);
        if (acc) begin
          sb_q.push_back(e);
          model_count = (model_count + 1) % (1 << CNT_W);
        end
        model_sticky = (model_sticky && !clr_sticky) || (acc && e.ovf);
      end
      pop_pending = 1'b0;
    end
  end

  initial begin
    logic [3:0] ops [8];
    checks       = 0;
    fails        = 0;
    pop_pending  = 1'b0;
    model_sticky = 1'b0;
    model_count  = 0;
    last_popped  = '{32'h0, 1'b0, 1'b0, 1'b0, 4'h0};
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
    ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b1010; ops[7] = 4'b1111;
    rst          = 1'b1;
    in_valid     = 1'b0;
    alu_result   = '0;
    alu_zero     = 1'b0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    alu_control  = '0;
    out_ready    = 1'b0;
    clr_sticky   = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Overflowing add 0x7FFFFFFF + 1 streams straight out.
    applyStimulus(1, 32'h8000_0000, 0, 0, 1, 4'b0010, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Three back-to-back pushes into a stalled FIFO; the third must bounce.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h1000 + i, 0, 1, 0, 4'b0110, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    end

    // Logical op with raw flags set: both must be masked.
    applyStimulus(1, 32'h0, 1, 1, 1, 4'b0000, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Set beats clear in the same cycle, then clear alone.
    applyStimulus(1, 32'h7FFF_FFFF, 0, 1, 1, 4'b0110, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // 17 streaming pushes from a fresh counter: wraps to 1.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                    4'b0010, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Fill, set sticky, then reset with the FIFO full.
    applyStimulus(1, 32'hAAAA_0001, 0, 0, 1, 4'b0010, 0, 0, 0);
    applyStimulus(1, 32'hAAAA_0002, 0, 0, 0, 4'b0010, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Randomised traffic, including unknown op codes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, 1'($urandom),
                    1'($urandom), 1'($urandom), ops[$urandom_range(0, 7)],
                    $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 99) == 0);
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    end
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
